// File: rtl/y_arb_mux_if.sv
// Handshake bundle between requesting channels, the y_arb_mux arbiter and its downstream consumer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface y_arb_mux_if #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                       mode;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*SIZE-1:0]   in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic                       out_valid;
  logic [SIZE-1:0]            out_data;
  logic [CHAN_W-1:0]          out_chan;
  logic                       out_ready;

  modport slave (
    input  mode,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_chan,
    input  out_ready
  );

  modport master (
    output mode,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_chan,
    output out_ready
  );
endinterface

// File: rtl/y_arb_mux.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
// Round-robin or fixed-priority grant, one beat per cycle when downstream keeps accepting.
module y_arb_mux #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  y_arb_mux_if.slave    bus
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHAN_W-1:0] PTR_RST = CHAN_W'(CHANNELS - 1);

  logic                  out_valid_r;
  logic [SIZE-1:0]       out_data_r;
  logic [CHAN_W-1:0]     out_chan_r;
  logic [CHAN_W-1:0]     ptr_r;

  logic                  ld_s;
  logic [CHANNELS-1:0]   gnt_s;
  logic [CHAN_W-1:0]     gnt_idx_s;
  logic [SIZE-1:0]       gnt_data_s;
  logic [CHANNELS-1:0]   in_ready_s;
  logic                  xfer_s;

  // Search starts just after the last winner and wraps modulo CHANNELS, so the
  // pointer never indexes past the last channel even for non-power-of-two counts.
  function automatic logic [CHANNELS-1:0] rr_pick(
    input logic [CHANNELS-1:0] req,
    input logic [CHAN_W-1:0]   last
  );
    logic [CHANNELS-1:0] gnt;
    logic                found;
    logic [CHAN_W-1:0]   sel;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      sel = CHAN_W'((int'(last) + k) % CHANNELS);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [CHANNELS-1:0] fp_pick(input logic [CHANNELS-1:0] req);
    logic [CHANNELS-1:0] gnt;
    logic                found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Grant selection, load enable, accept strobes and the granted channel's data.
  always_comb begin
    ld_s       = !out_valid_r || bus.out_ready;
    gnt_s      = '0;
    gnt_idx_s  = '0;
    gnt_data_s = '0;
    in_ready_s = '0;
    if (bus.mode) begin
      gnt_s = fp_pick(bus.in_valid);
    end else begin
      gnt_s = rr_pick(bus.in_valid, ptr_r);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      gnt_idx_s  = gnt_idx_s | (gnt_s[i] ? CHAN_W'(i) : '0);
      gnt_data_s = gnt_data_s | ({SIZE{gnt_s[i]}} & bus.in_data[i*SIZE +: SIZE]);
    end
    // Gating with rst_n keeps the accepts low during reset without waiting for a clock.
    if (ld_s && rst_n) begin
      in_ready_s = gnt_s;
    end else begin
      in_ready_s = '0;
    end
    xfer_s = |(in_ready_s & bus.in_valid);
  end

  // Output register and round-robin pointer; reload on transfer, drain when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
      ptr_r       <= PTR_RST;
    end else if (ld_s) begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= gnt_data_s;
        out_chan_r  <= gnt_idx_s;
        ptr_r       <= gnt_idx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_chan  = out_chan_r;

endmodule

// File: tb/tb_y_arb_mux.sv
// Directed bench for y_arb_mux (SIZE=32, CHANNELS=4) with hand-computed expectations.
module tb_y_arb_mux;
  localparam int SIZE     = 32;
  localparam int CHANNELS = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  y_arb_mux_if #(.SIZE(SIZE), .CHANNELS(CHANNELS)) bus ();

  y_arb_mux #(.SIZE(SIZE), .CHANNELS(CHANNELS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    check_val({tag, "_data"},  64'(bus.out_data),  64'(d));
    check_val({tag, "_chan"},  64'(bus.out_chan),  64'(c));
  endtask

  initial begin
    logic [1:0] exp_chan;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.in_data[i*SIZE +: SIZE] = 32'hA5A5_0000 | 32'(i);
    end

    // Reset held with every channel requesting.
    #2;
    check_out("rst_a", 1'b0, 32'h0, 2'd0);
    check_val("rst_a_rdy", 64'(bus.in_ready), 64'h0);
    tick();
    tick();
    check_out("rst_b", 1'b0, 32'h0, 2'd0);
    check_val("rst_b_rdy", 64'(bus.in_ready), 64'h0);

    // Round-robin from reset: first grant to ch0, then rotate.
    rst_n = 1'b1;
    #1;
    check_val("rr_first_rdy", 64'(bus.in_ready), 64'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_chan = 2'(k % 4);
      check_out($sformatf("rr_beat%0d", k), 1'b1, 32'hA5A5_0000 | 32'(exp_chan), exp_chan);
    end

    // Fixed priority: ch0 wins regardless of pointer, then ch1 once ch0 drops.
    bus.mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("fp_chan%0d", k), 64'(bus.out_chan), 64'd0);
    end
    bus.in_valid = 4'b1110;
    tick();
    check_val("fp_drop0_chan", 64'(bus.out_chan), 64'd1);
    tick();
    check_val("fp_drop0_chan2", 64'(bus.out_chan), 64'd1);

    // Single requester on ch2: same-cycle accept, one-cycle latency, then drain.
    bus.mode     = 1'b0;
    bus.in_valid = 4'b0100;
    #1;
    check_val("single_rdy", 64'(bus.in_ready), 64'b0100);
    tick();
    check_out("single", 1'b1, 32'hA5A5_0002, 2'd2);
    bus.in_valid = 4'b0000;
    #1;
    check_val("idle_rdy", 64'(bus.in_ready), 64'h0);
    tick();
    check_out("drain", 1'b0, 32'hA5A5_0002, 2'd2);

    // Backpressure: hold ch1 beat 0x11 for 3 cycles while ch2 waits.
    bus.in_data[1*SIZE +: SIZE] = 32'h0000_0011;
    bus.in_valid = 4'b0010;
    tick();
    check_out("bp_load", 1'b1, 32'h0000_0011, 2'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("bp_rdy%0d", k), 64'(bus.in_ready), 64'h0);
      tick();
      check_out($sformatf("bp_hold%0d", k), 1'b1, 32'h0000_0011, 2'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_release_rdy", 64'(bus.in_ready), 64'b0100);
    tick();
    check_out("bp_reload", 1'b1, 32'hA5A5_0002, 2'd2);

    // Reset pulse between edges discards the held beat at once.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("pulse", 1'b0, 32'h0, 2'd0);
    check_val("pulse_rdy", 64'(bus.in_ready), 64'h0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_val("post_rst_rdy", 64'(bus.in_ready), 64'b0010);
    tick();
    check_out("post_rst", 1'b1, 32'h0000_0011, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
